// File: rtl/eq2.sv
// eq2: W-bit equality compare; aeqb is combinational, the rest are registered once on clk.
// Latency: aeqb 0 cycles, all other outputs 1 cycle. No backpressure: every edge samples.
// EQ2_STATS_EN builds the saturating match/mismatch counters; otherwise both read 0.
module eq2 #(
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             clr,
  output logic             aeqb,
  output logic             aeqb_q,
  output logic             eq_rise,
  output logic             eq_fall,
  output logic             sticky_neq,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt
);

  assign aeqb = &(a ~^ b);

  // Pulses compare the new sample against the previous registered one,
  // so they land on the same edge at which aeqb_q changes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      aeqb_q     <= 1'b0;
      eq_rise    <= 1'b0;
      eq_fall    <= 1'b0;
      sticky_neq <= 1'b0;
    end else begin
      aeqb_q  <= aeqb;
      eq_rise <= aeqb & ~aeqb_q;
      eq_fall <= ~aeqb & aeqb_q;
      if (clr)
        sticky_neq <= 1'b0;
      else if (!aeqb)
        sticky_neq <= 1'b1;
    end
  end

`ifdef EQ2_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
    end else if (aeqb) begin
      if (match_cnt != CNT_MAX)
        match_cnt <= match_cnt + CNT_W'(1);
    end else begin
      if (mismatch_cnt != CNT_MAX)
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end
`else
  assign match_cnt    = '0;
  assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_eq2.sv
// Randomized scoreboard bench for eq2: a default-width instance plus a CNT_W=2 instance for saturation.
module tb_eq2;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] a, b;
  logic       clr;

  logic       aeqb, aeqb_q, eq_rise, eq_fall, sticky_neq;
  logic [7:0] match_cnt, mismatch_cnt;
  logic       s_aeqb, s_aeqb_q, s_eq_rise, s_eq_fall, s_sticky_neq;
  logic [1:0] s_match_cnt, s_mismatch_cnt;

  eq2 #(.W(2), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clr(clr),
    .aeqb(aeqb), .aeqb_q(aeqb_q), .eq_rise(eq_rise), .eq_fall(eq_fall),
    .sticky_neq(sticky_neq), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt)
  );

  eq2 #(.W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clr(clr),
    .aeqb(s_aeqb), .aeqb_q(s_aeqb_q), .eq_rise(s_eq_rise), .eq_fall(s_eq_fall),
    .sticky_neq(s_sticky_neq), .match_cnt(s_match_cnt), .mismatch_cnt(s_mismatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic q, rise, fall, sticky;
    int   mc, mmc, mc2, mmc2;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: history of the last sample plus unbounded event counts.
  bit m_prev   = 1'b0;
  bit m_sticky = 1'b0;
  bit m_rise   = 1'b0;
  bit m_fall   = 1'b0;
  int m_match  = 0;
  int m_miss   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
`ifdef EQ2_STATS_EN
    return (v > mx) ? mx : v;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle of stimulus, check the combinational result, and queue the registered prediction.
  task automatic step(input logic [1:0] ta, input logic [1:0] tb_, input logic tclr, input logic trst);
    bit   eq;
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_; clr = tclr; reset_n = trst;
    #1;
    eq = (ta == tb_);
    chk("aeqb", {31'd0, aeqb}, {31'd0, eq});
    chk("aeqb_sat", {31'd0, s_aeqb}, {31'd0, eq});
    if (!trst) begin
      m_prev = 0; m_rise = 0; m_fall = 0; m_sticky = 0; m_match = 0; m_miss = 0;
    end else begin
      m_rise = eq && !m_prev;
      m_fall = !eq && m_prev;
      m_prev = eq;
      if (tclr) begin
        m_sticky = 0; m_match = 0; m_miss = 0;
      end else begin
        if (!eq) m_sticky = 1;
        if (eq) m_match++; else m_miss++;
      end
    end
    e.q = m_prev; e.rise = m_rise; e.fall = m_fall; e.sticky = m_sticky;
    e.mc  = sat(m_match, 255); e.mmc  = sat(m_miss, 255);
    e.mc2 = sat(m_match, 3);   e.mmc2 = sat(m_miss, 3);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [1:0] ta, input logic [1:0] tb_, input logic tclr, input int n);
    for (int i = 0; i < n; i++) step(ta, tb_, tclr, 1'b1);
  endtask

  // Monitor: every edge presents a fresh set of registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("aeqb_q",       {31'd0, aeqb_q},       {31'd0, e.q});
        chk("eq_rise",      {31'd0, eq_rise},      {31'd0, e.rise});
        chk("eq_fall",      {31'd0, eq_fall},      {31'd0, e.fall});
        chk("sticky_neq",   {31'd0, sticky_neq},   {31'd0, e.sticky});
        chk("match_cnt",    {24'd0, match_cnt},    e.mc);
        chk("mismatch_cnt", {24'd0, mismatch_cnt}, e.mmc);
        chk("sat_aeqb_q",   {31'd0, s_aeqb_q},     {31'd0, e.q});
        chk("sat_rise",     {31'd0, s_eq_rise},    {31'd0, e.rise});
        chk("sat_fall",     {31'd0, s_eq_fall},    {31'd0, e.fall});
        chk("sat_sticky",   {31'd0, s_sticky_neq}, {31'd0, e.sticky});
        chk("sat_match",    {30'd0, s_match_cnt},  e.mc2);
        chk("sat_mismatch", {30'd0, s_mismatch_cnt}, e.mmc2);
      end
    end
  end

  logic [1:0] va[7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
  logic [1:0] vb[7] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};

  initial begin
    logic [1:0] ra, rb;
    a = 2'b11; b = 2'b11; clr = 1'b0; reset_n = 1'b0;

    // Truth table, each vector held 200 ns.
    for (int v = 0; v < 7; v++) hold(va[v], vb[v], 1'b0, 20);

    // Reset with equal operands, then release.
    for (int i = 0; i < 3; i++) step(2'b11, 2'b11, 1'b0, 1'b0);
    hold(2'b11, 2'b11, 1'b0, 3);

    // Single-cycle mismatch pulse.
    hold(2'b01, 2'b01, 1'b0, 4);
    hold(2'b01, 2'b00, 1'b0, 1);
    hold(2'b01, 2'b01, 1'b0, 4);

    // Counter sequence, then clear.
    hold(2'b10, 2'b10, 1'b1, 1);
    hold(2'b10, 2'b10, 1'b0, 5);
    hold(2'b10, 2'b01, 1'b0, 3);
    hold(2'b10, 2'b10, 1'b1, 1);
    hold(2'b00, 2'b00, 1'b0, 6);

    // Random traffic, biased toward equality, with occasional clr and reset.
    for (int i = 0; i < 600; i++) begin
      ra = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 1) == 1) ? ra : 2'($urandom_range(0, 3));
      step(ra, rb, ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
